numeros_com_sinal_pipe: RTL

- Parametrised, pipelined successor to the combinational signed/unsigned operator.
- Accepts one signed pair and one unsigned pair per transaction, plus an operation code. The operation set adds subtract, mixed-sign add, multiply and a running accumulator.
- Produces a WO-bit signed result with an overflow flag. Both input and output sides use a valid/ready handshake.
- Sits between the lab's stimulus or register interface and any downstream consumer of signed results.

---
 rtl/numeros_com_sinal_pipe_pkg.sv | 46 ++++
 rtl/numeros_com_sinal_pipe_if.sv | 36 +++
 rtl/numeros_com_sinal_pipe_satura.sv | 28 ++
 rtl/numeros_com_sinal_pipe.sv | 130 +++++++++++++
 4 files changed

// File: rtl/numeros_com_sinal_pipe_pkg.sv
// numeros_pkg: op-code encodings and the shared clamp/wrap function used by
// the signed/unsigned pipelined operator.
//   OP_*         3-bit operation codes carried on codigo
//   RAW_MAX      widest raw value the helper function accepts
//   sat_res_t    helper result: {value (RAW_MAX bits), overflow flag}
//   sat_or_wrap  range-checks a raw value against a wo-bit signed range and
//                either clamps it or keeps its low wo bits (sign-extended)
package numeros_pkg;

  localparam logic [2:0] OP_SADD = 3'd0;
  localparam logic [2:0] OP_UADD = 3'd1;
  localparam logic [2:0] OP_SSUB = 3'd2;
  localparam logic [2:0] OP_MIX  = 3'd3;
  localparam logic [2:0] OP_SMUL = 3'd4;
  localparam logic [2:0] OP_ACC  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  // Callers sign-extend their raw value up to this width first.
  localparam int RAW_MAX = 64;

  typedef struct packed {
    logic [RAW_MAX-1:0] val;
    logic               ovf;
  } sat_res_t;

  function automatic sat_res_t sat_or_wrap(input logic signed [RAW_MAX-1:0] raw,
                                           input logic                      sat,
                                           input int                        wo);
    logic signed [RAW_MAX-1:0] hi;
    logic signed [RAW_MAX-1:0] lo;
    logic signed [RAW_MAX-1:0] wrapped;
    sat_res_t                  r;
    hi      = (64'sd1 <<< (wo - 1)) - 64'sd1;
    lo      = ~hi;
    // Shift the low wo bits to the top and back to sign-extend them.
    wrapped = (raw <<< (RAW_MAX - wo)) >>> (RAW_MAX - wo);
    r.ovf   = (raw > hi) || (raw < lo);
    if (sat && r.ovf)
      r.val = (raw > hi) ? hi : lo;
    else
      r.val = wrapped;
    return r;
  endfunction

endpackage

// File: rtl/numeros_com_sinal_pipe_if.sv
// Handshake/data bundle of numeros_com_sinal_pipe.
//   entrada_signed_1/2, entrada_unsigned_1/2, codigo, in_valid : request side
//   in_ready                                                    : request accept
//   saida, overflow, erro, out_valid                            : result side
//   out_ready                                                   : result accept
// master = producer/consumer around the block, slave = the block itself.
interface numeros_com_sinal_pipe_if #(
  parameter int W1 = 8,
  parameter int W2 = 4,
  parameter int WO = 8
);
  logic signed [W1-1:0] entrada_signed_1;
  logic signed [W2-1:0] entrada_signed_2;
  logic        [W1-1:0] entrada_unsigned_1;
  logic        [W2-1:0] entrada_unsigned_2;
  logic        [2:0]    codigo;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [WO-1:0] saida;
  logic                 overflow;
  logic                 erro;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output entrada_signed_1, entrada_signed_2, entrada_unsigned_1,
           entrada_unsigned_2, codigo, in_valid, out_ready,
    input  in_ready, saida, overflow, erro, out_valid
  );

  modport slave (
    input  entrada_signed_1, entrada_signed_2, entrada_unsigned_1,
           entrada_unsigned_2, codigo, in_valid, out_ready,
    output in_ready, saida, overflow, erro, out_valid
  );
endinterface

// File: rtl/numeros_com_sinal_pipe_satura.sv
// numeros_satura: combinational clamp (SAT=1) or two's-complement wrap (SAT=0)
// of a WR-bit signed raw value down to WO bits, with an out-of-range flag.
//   raw : WR-bit signed input
//   val : WO-bit signed result
//   ovf : raw was outside the WO-bit signed range
module numeros_satura
  import numeros_pkg::*;
#(
  parameter int WR  = 17,
  parameter int WO  = 8,
  parameter int SAT = 1
) (
  input  logic signed [WR-1:0] raw,
  output logic signed [WO-1:0] val,
  output logic                 ovf
);

  logic signed [RAW_MAX-1:0] raw_x;
  sat_res_t                  res;
  logic [RAW_MAX-WO-1:0]     hi_bits_unused;

  assign raw_x          = {{(RAW_MAX-WR){raw[WR-1]}}, raw};
  assign res            = sat_or_wrap(raw_x, SAT != 0, WO);
  assign val            = res.val[WO-1:0];
  assign hi_bits_unused = res.val[RAW_MAX-1:WO];
  assign ovf            = res.ovf;

endmodule

// File: rtl/numeros_com_sinal_pipe.sv
// numeros_com_sinal_pipe: two-stage pipelined signed/unsigned operator.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, flushes both stages and acc
//   bus : slave side of numeros_com_sinal_pipe_if (valid/ready in and out)
// Stage 1 forms a WO+W1+1 bit raw result; stage 2 clamps or wraps it to WO
// bits. Both stages share one enable, so a stalled output freezes the whole
// pipe. The accumulator is updated at accept time with the already
// clamped/wrapped value, so back-to-back ACC operations chain without hazard.
module numeros_com_sinal_pipe
  import numeros_pkg::*;
#(
  parameter int W1  = 8,
  parameter int W2  = 4,
  parameter int WO  = 8,
  parameter int SAT = 1
) (
  input logic                     clk,
  input logic                     rst,
  numeros_com_sinal_pipe_if.slave bus
);

  localparam int WR = WO + W1 + 1;

  logic                 en;
  logic                 accept;

  logic signed [WR-1:0] a_x;
  logic signed [WR-1:0] b_x;
  logic signed [WR-1:0] c_x;
  logic signed [WR-1:0] d_x;
  logic signed [WR-1:0] acc_x;
  logic signed [WR-1:0] raw_c;

  logic signed [WO-1:0] acc;
  logic signed [WO-1:0] acc_next;
  logic                 acc_ovf_unused;

  logic                 s1_valid;
  logic signed [WR-1:0] s1_raw;
  logic                 s1_rsvd;

  logic signed [WO-1:0] sat_val;
  logic                 sat_ovf;

  logic                 s2_valid;
  logic signed [WO-1:0] saida_q;
  logic                 ovf_q;
  logic                 erro_q;

  // Output stall freezes everything; in_ready follows out_ready combinationally.
  assign en           = !s2_valid || bus.out_ready;
  assign accept       = bus.in_valid && en;
  assign bus.in_ready = en;

  assign a_x   = {{(WR-W1){bus.entrada_signed_1[W1-1]}}, bus.entrada_signed_1};
  assign b_x   = {{(WR-W2){bus.entrada_signed_2[W2-1]}}, bus.entrada_signed_2};
  assign c_x   = {{(WR-W1){1'b0}}, bus.entrada_unsigned_1};
  assign d_x   = {{(WR-W2){1'b0}}, bus.entrada_unsigned_2};
  assign acc_x = {{(WR-WO){acc[WO-1]}}, acc};

  // WR covers the full W1+W2 product, so the low WR bits of the product are exact.
  always_comb begin
    raw_c = '0;
    case (bus.codigo)
      OP_SADD: raw_c = a_x + b_x;
      OP_UADD: raw_c = c_x + d_x;
      OP_SSUB: raw_c = a_x - b_x;
      OP_MIX:  raw_c = a_x + d_x;
      OP_SMUL: raw_c = a_x * b_x;
      OP_ACC:  raw_c = acc_x + a_x;
      default: raw_c = '0;
    endcase
  end

  numeros_satura #(.WR(WR), .WO(WO), .SAT(SAT)) u_acc_sat (
    .raw (raw_c),
    .val (acc_next),
    .ovf (acc_ovf_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      if (bus.codigo == OP_ACC)
        acc <= acc_next;
      else if (bus.codigo == OP_CLR)
        acc <= '0;
    end
  end

  // Bubbles carry a zero raw so stage 2 never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_rsvd  <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_raw   <= bus.in_valid ? raw_c : '0;
      s1_rsvd  <= bus.in_valid && (bus.codigo == OP_RSVD);
    end
  end

  numeros_satura #(.WR(WR), .WO(WO), .SAT(SAT)) u_out_sat (
    .raw (s1_raw),
    .val (sat_val),
    .ovf (sat_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      saida_q  <= '0;
      ovf_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      saida_q  <= sat_val;
      ovf_q    <= sat_ovf;
      erro_q   <= s1_rsvd;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.saida     = saida_q;
  assign bus.overflow  = ovf_q;
  assign bus.erro      = erro_q;

endmodule
